// File: rtl/coin_arbiter.sv
// coin_arbiter: merges two coin slots into registered one/two/five pulses
// for the vending FSM, with round-robin arbitration, a forced gap after
// every pulse and a holdoff after every dispense indication.
// Optional macro COIN_ARBITER_FIFO_EN: each slot gets a 2-entry in-order
// FIFO instead of the default single-entry buffer.

module coin_arbiter_buf #(
    parameter int DEPTH = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  logic [1:0] push_code,
    input  logic       pop,
    output logic [1:0] head,
    output logic       empty,
    output logic       full
);

    logic [1:0] mem0;
    logic [1:0] mem1;
    logic [1:0] count;

    // Keep up to DEPTH codes in arrival order; mem0 is always the head, and
    // a push and pop in the same cycle are both applied.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= 2'd0;
            mem0  <= 2'b00;
            mem1  <= 2'b00;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0)
                        mem0 <= push_code;
                    else
                        mem1 <= push_code;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    mem0  <= mem1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        mem0 <= push_code;
                    end else begin
                        mem0 <= mem1;
                        mem1 <= push_code;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign head  = mem0;
    assign empty = (count == 2'd0);
    assign full  = (count == 2'(DEPTH));

endmodule

module coin_arbiter #(
    parameter int GAP  = 1,
    parameter int LOCK = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_valid,
    input  logic [1:0] a_coin,
    output logic       a_ready,
    input  logic       b_valid,
    input  logic [1:0] b_coin,
    output logic       b_ready,
    input  logic       d_in,
    output logic       one,
    output logic       two,
    output logic       five,
    output logic       err_coin,
    output logic       busy
);

`ifdef COIN_ARBITER_FIFO_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_GAP,
        ST_LOCK
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       d_pend;
    logic       last_grant_b;

    logic       a_fire;
    logic       b_fire;
    logic       a_push;
    logic       b_push;
    logic       a_bad;
    logic       b_bad;
    logic       a_pop;
    logic       b_pop;
    logic [1:0] a_head;
    logic [1:0] b_head;
    logic       a_empty;
    logic       b_empty;
    logic       a_full;
    logic       b_full;
    logic       a_ne;
    logic       b_ne;
    logic       decide;
    logic       lock_req;
    logic       issue;
    logic       grant_a;
    logic [1:0] grant_code;

    // A transfer happens on valid & ready; code 00 is consumed but never buffered.
    assign a_fire = a_valid & a_ready;
    assign b_fire = b_valid & b_ready;
    assign a_push = a_fire & (a_coin != 2'b00);
    assign b_push = b_fire & (b_coin != 2'b00);
    assign a_bad  = a_fire & (a_coin == 2'b00);
    assign b_bad  = b_fire & (b_coin == 2'b00);

    assign a_ready = ~a_full;
    assign b_ready = ~b_full;
    assign a_ne    = ~a_empty;
    assign b_ne    = ~b_empty;

    // The last GAP cycle arbitrates exactly like IDLE, so back-to-back coins
    // are spaced 1+GAP cycles; a dispense seen this very cycle also counts.
    assign decide     = (state == ST_IDLE) || ((state == ST_GAP) && (cnt == 4'd0));
    assign lock_req   = d_pend | d_in;
    assign issue      = decide & ~lock_req & (a_ne | b_ne);
    assign grant_a    = a_ne & (~b_ne | last_grant_b);
    assign grant_code = grant_a ? a_head : b_head;
    assign a_pop      = issue & grant_a;
    assign b_pop      = issue & ~grant_a;

    assign busy = (state != ST_IDLE) | a_ne | b_ne;

    coin_arbiter_buf #(.DEPTH(DEPTH)) u_buf_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (a_push),
        .push_code (a_coin),
        .pop       (a_pop),
        .head      (a_head),
        .empty     (a_empty),
        .full      (a_full)
    );

    coin_arbiter_buf #(.DEPTH(DEPTH)) u_buf_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (b_push),
        .push_code (b_coin),
        .pop       (b_pop),
        .head      (b_head),
        .empty     (b_empty),
        .full      (b_full)
    );

    // Sequencer: IDLE/GAP-exit arbitration, one-cycle ISSUE pulse, timed GAP and LOCK phases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            one          <= 1'b0;
            two          <= 1'b0;
            five         <= 1'b0;
            d_pend       <= 1'b0;
            last_grant_b <= 1'b1;
        end else begin
            one  <= 1'b0;
            two  <= 1'b0;
            five <= 1'b0;
            if (d_in)
                d_pend <= 1'b1;
            if (decide) begin
                if (lock_req) begin
                    state  <= ST_LOCK;
                    cnt    <= 4'(LOCK - 1);
                    d_pend <= 1'b0;
                end else if (issue) begin
                    state        <= ST_ISSUE;
                    one          <= (grant_code == 2'b01);
                    two          <= (grant_code == 2'b10);
                    five         <= (grant_code == 2'b11);
                    last_grant_b <= ~grant_a;
                end else begin
                    state <= ST_IDLE;
                end
            end else begin
                case (state)
                    ST_ISSUE: begin
                        state <= ST_GAP;
                        cnt   <= 4'(GAP - 1);
                    end
                    ST_GAP, ST_LOCK: begin
                        if (cnt == 4'd0)
                            state <= ST_IDLE;
                        else
                            cnt <= cnt - 4'd1;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // A single error pulse covers one or both slots delivering code 00.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            err_coin <= 1'b0;
        else
            err_coin <= a_bad | b_bad;
    end

endmodule
